// File: rtl/spram_be_clr_pkg.sv
// Shared constants, FSM state type and lane helper for the byte-enable
// single-port RAM with hardware clear.
package spram_be_clr_pkg;

  localparam int unsigned RDW_WRITE_FIRST = 0;
  localparam int unsigned RDW_READ_FIRST  = 1;
  localparam int unsigned RDW_NO_CHANGE   = 2;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  function automatic int unsigned lanes(input int unsigned data_width,
                                        input int unsigned byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/spram_be_clr_if.sv
// User-side bus of spram_be_clr: access request, read data and clear control.
interface spram_be_clr_if
  import spram_be_clr_pkg::*;
#(
  parameter int unsigned address_width = 8,
  parameter int unsigned data_width    = 8,
  parameter int unsigned byte_width    = 8
);
  localparam int unsigned LANES = lanes(data_width, byte_width);

  logic [address_width-1:0] address;
  logic [data_width-1:0]    data;
  logic [LANES-1:0]         byte_en;
  logic                     wren;
  logic                     rden;
  logic                     clear_req;
  logic [data_width-1:0]    q;
  logic                     q_valid;
  logic                     busy;

  modport master (
    output address, data, byte_en, wren, rden, clear_req,
    input  q, q_valid, busy
  );

  modport slave (
    input  address, data, byte_en, wren, rden, clear_req,
    output q, q_valid, busy
  );
endinterface

// File: rtl/spram_be_clr_seq.sv
// Clear sequencer: sweeps every address once after reset or on clear_req,
// holding busy for the whole sweep.
module spram_be_clr_seq
  import spram_be_clr_pkg::*;
#(
  parameter int unsigned address_width = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear_req_i,
  output logic                     busy_o,
  output logic                     clr_we_o,
  output logic [address_width-1:0] clr_addr_o
);

  localparam logic [address_width-1:0] LAST_ADDR = '1;

  state_e                   state_q;
  logic [address_width-1:0] clr_addr_q;
  logic                     busy_q;

  // busy tracks ST_CLEAR exactly, so it also serves as the sweep write strobe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          clr_addr_q <= clr_addr_q + address_width'(1);
          if (clr_addr_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (clear_req_i) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_CLEAR;
          clr_addr_q <= '0;
          busy_q     <= 1'b1;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign clr_we_o   = busy_q;
  assign clr_addr_o = clr_addr_q;

endmodule

// File: rtl/spram_be_clr.sv
// Single-port RAM with per-byte write enables, selectable read-during-write
// and a clear sweep. Define SPRAM_BE_CLR_OUTREG_EN for a second output stage.
module spram_be_clr
  import spram_be_clr_pkg::*;
#(
  parameter int unsigned          address_width = 8,
  parameter int unsigned          data_width    = 8,
  parameter int unsigned          byte_width    = 8,
  parameter int unsigned          rdw_mode      = 0,
  parameter logic [data_width-1:0] clear_value  = '0
) (
  input logic          clock,
  input logic          reset,
  spram_be_clr_if.slave bus
);

  localparam int unsigned LANES = lanes(data_width, byte_width);
  localparam int unsigned DEPTH = 2 ** address_width;

  generate
    if ((byte_width == 0) || ((data_width % byte_width) != 0) || (rdw_mode > RDW_NO_CHANGE)) begin : g_param_check
      $error("spram_be_clr: illegal data_width/byte_width/rdw_mode combination");
    end
  endgenerate

  logic [data_width-1:0]    mem [DEPTH];
  logic                     busy;
  logic                     clr_we;
  logic [address_width-1:0] clr_addr;
  logic                     user_wr;
  logic                     user_rd;
  logic [data_width-1:0]    old_word;
  logic [data_width-1:0]    merged_word;
  logic [data_width-1:0]    q_d;
  logic [data_width-1:0]    q_q;
  logic                     q_valid_d;
  logic                     q_valid_q;

  spram_be_clr_seq #(
    .address_width(address_width)
  ) u_seq (
    .clock       (clock),
    .reset       (reset),
    .clear_req_i (bus.clear_req),
    .busy_o      (busy),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr)
  );

  assign user_wr  = !busy && bus.wren;
  assign user_rd  = !busy && bus.rden;
  assign old_word = mem[bus.address];

  // Lanes without byte_en keep the stored value
  always_comb begin
    merged_word = old_word;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (bus.byte_en[i]) begin
        merged_word[i*byte_width +: byte_width] = bus.data[i*byte_width +: byte_width];
      end
    end
  end

  // Array is never reset; only the sweep initialises it
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_addr] <= clear_value;
    end else if (user_wr) begin
      mem[bus.address] <= merged_word;
    end
  end

  always_comb begin
    q_d       = q_q;
    q_valid_d = 1'b0;
    if (user_rd) begin
      if (!bus.wren) begin
        q_d       = old_word;
        q_valid_d = 1'b1;
      end else if (rdw_mode == RDW_WRITE_FIRST) begin
        q_d       = merged_word;
        q_valid_d = 1'b1;
      end else if (rdw_mode == RDW_READ_FIRST) begin
        q_d       = old_word;
        q_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

`ifdef SPRAM_BE_CLR_OUTREG_EN
  logic [data_width-1:0] q2_q;
  logic                  q_valid2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q2_q       <= '0;
      q_valid2_q <= 1'b0;
    end else begin
      q2_q       <= q_q;
      q_valid2_q <= q_valid_q;
    end
  end

  assign bus.q       = q2_q;
  assign bus.q_valid = q_valid2_q;
`else
  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
`endif

  assign bus.busy = busy;

endmodule

// File: tb/tb_spram_be_clr.sv
// Bench for spram_be_clr: four instances (three 8-bit rdw modes, one 16-bit
// two-lane) share one stimulus and are checked against a behavioural model.
`timescale 1ns/1ps
module tb_spram_be_clr;

  localparam int unsigned AW    = 4;
  localparam int          DEPTH = 16;
`ifdef SPRAM_BE_CLR_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic [7:0]  CLR8  = 8'hA5;
  localparam logic [15:0] CLR16 = 16'h5AA5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] address;
  logic [15:0]   data16;
  logic [1:0]    be;
  logic          wren, rden, clear_req;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clock = ~clock;

  spram_be_clr_if #(.address_width(AW), .data_width(8),  .byte_width(8)) if_m0 ();
  spram_be_clr_if #(.address_width(AW), .data_width(8),  .byte_width(8)) if_m1 ();
  spram_be_clr_if #(.address_width(AW), .data_width(8),  .byte_width(8)) if_m2 ();
  spram_be_clr_if #(.address_width(AW), .data_width(16), .byte_width(8)) if_w  ();

  assign if_m0.address = address;  assign if_m0.data = data16[7:0];  assign if_m0.byte_en = be[0];
  assign if_m0.wren = wren;        assign if_m0.rden = rden;         assign if_m0.clear_req = clear_req;
  assign if_m1.address = address;  assign if_m1.data = data16[7:0];  assign if_m1.byte_en = be[0];
  assign if_m1.wren = wren;        assign if_m1.rden = rden;         assign if_m1.clear_req = clear_req;
  assign if_m2.address = address;  assign if_m2.data = data16[7:0];  assign if_m2.byte_en = be[0];
  assign if_m2.wren = wren;        assign if_m2.rden = rden;         assign if_m2.clear_req = clear_req;
  assign if_w.address  = address;  assign if_w.data  = data16;       assign if_w.byte_en  = be;
  assign if_w.wren  = wren;        assign if_w.rden  = rden;         assign if_w.clear_req  = clear_req;

  spram_be_clr #(.address_width(AW), .data_width(8), .byte_width(8), .rdw_mode(0), .clear_value(CLR8))
    u_m0 (.clock(clock), .reset(reset), .bus(if_m0));
  spram_be_clr #(.address_width(AW), .data_width(8), .byte_width(8), .rdw_mode(1), .clear_value(CLR8))
    u_m1 (.clock(clock), .reset(reset), .bus(if_m1));
  spram_be_clr #(.address_width(AW), .data_width(8), .byte_width(8), .rdw_mode(2), .clear_value(CLR8))
    u_m2 (.clock(clock), .reset(reset), .bus(if_m2));
  spram_be_clr #(.address_width(AW), .data_width(16), .byte_width(8), .rdw_mode(0), .clear_value(CLR16))
    u_w  (.clock(clock), .reset(reset), .bus(if_w));

  logic [15:0] dq [4];
  logic        dv [4];
  logic        db [4];
  assign dq[0] = {8'h00, if_m0.q}; assign dv[0] = if_m0.q_valid; assign db[0] = if_m0.busy;
  assign dq[1] = {8'h00, if_m1.q}; assign dv[1] = if_m1.q_valid; assign db[1] = if_m1.busy;
  assign dq[2] = {8'h00, if_m2.q}; assign dv[2] = if_m2.q_valid; assign db[2] = if_m2.busy;
  assign dq[3] = if_w.q;           assign dv[3] = if_w.q_valid;  assign db[3] = if_w.busy;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one shared word array (8-bit parts see its low lane),
  // a sweep countdown, and per-instance result pipeline.
  logic [15:0] m_mem [DEPTH];
  int          sweep_left = DEPTH;
  logic [15:0] m_q1 [4];
  logic [15:0] m_q2 [4];
  logic        m_v1 [4];
  logic        m_v2 [4];
  logic [15:0] old_w, new_w, mask;
  int          mode;

  always begin
    @(posedge clock);
    if (reset) begin
      sweep_left = DEPTH;
      for (int k = 0; k < 4; k++) begin
        m_q1[k] = '0; m_v1[k] = 1'b0; m_q2[k] = '0; m_v2[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        m_q2[k] = m_q1[k]; m_v2[k] = m_v1[k];
      end
      if (sweep_left > 0) begin
        m_mem[DEPTH - sweep_left] = CLR16;
        sweep_left--;
        for (int k = 0; k < 4; k++) m_v1[k] = 1'b0;
      end else begin
        old_w = m_mem[address];
        new_w = old_w;
        if (wren) begin
          if (be[0]) new_w[7:0]  = data16[7:0];
          if (be[1]) new_w[15:8] = data16[15:8];
          m_mem[address] = new_w;
        end
        for (int k = 0; k < 4; k++) begin
          mask    = (k == 3) ? 16'hFFFF : 16'h00FF;
          mode    = (k == 3) ? 0 : k;
          m_v1[k] = 1'b0;
          if (rden && !wren) begin
            m_q1[k] = old_w & mask; m_v1[k] = 1'b1;
          end else if (rden && wren && mode == 0) begin
            m_q1[k] = new_w & mask; m_v1[k] = 1'b1;
          end else if (rden && wren && mode == 1) begin
            m_q1[k] = old_w & mask; m_v1[k] = 1'b1;
          end
        end
        if (clear_req) sweep_left = DEPTH;
      end
    end
    #1;
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("model_q[%0d]", k), dq[k], (LAT == 2) ? m_q2[k] : m_q1[k]);
        check($sformatf("model_qv[%0d]", k), 16'(dv[k]), 16'((LAT == 2) ? m_v2[k] : m_v1[k]));
        check($sformatf("model_busy[%0d]", k), 16'(db[k]), 16'(sweep_left != 0));
      end
    end
  end

  task automatic idle();
    wren = 1'b0; rden = 1'b0; clear_req = 1'b0; be = 2'b00;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] b);
    address = a; data16 = d; be = b; wren = 1'b1; rden = 1'b0;
    @(negedge clock);
    idle();
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [7:0] e8, input logic [15:0] e16);
    address = a; rden = 1'b1; wren = 1'b0;
    @(posedge clock); #1;
    idle();
    if (LAT == 2) begin @(posedge clock); #1; end
    check($sformatf("rd8_q@%0d", a), {8'h00, if_m0.q}, {8'h00, e8});
    check($sformatf("rd8_qv@%0d", a), 16'(if_m0.q_valid), 16'd1);
    check($sformatf("rd16_q@%0d", a), if_w.q, e16);
    @(negedge clock);
  endtask

  // Counts edges from sweep start until busy falls; optional junk traffic
  // (write/read addr 2 plus one clear_req) that must all be ignored.
  task automatic count_sweep(input bit junk, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (junk) begin
        address = 2; data16 = 16'h0055; be = 2'b11; wren = 1'b1; rden = 1'b1;
        clear_req = (i == 4);
      end
      @(posedge clock); #1;
      n++;
      if (!if_m0.busy) break;
      @(negedge clock);
    end
    idle();
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n;

  initial begin
    idle(); address = '0; data16 = '0;
    #2 reset = 1'b1;
    @(negedge clock);
    chk_en = 1'b1;
    @(negedge clock);
    check("reset_busy", 16'(if_m0.busy), 16'd1);
    check("reset_q", if_w.q, 16'h0000);
    check("reset_qv", 16'(if_w.q_valid), 16'd0);
    reset = 1'b0;
    count_sweep(1'b0, n);
    check("sweep_len_reset", 16'(n), 16'd16);
    for (int a = 0; a < DEPTH; a++) rd(AW'(a), CLR8, CLR16);

    // byte enables
    wr(3, 16'h1234, 2'b11);
    wr(3, 16'hABCD, 2'b01);
    rd(3, 8'hCD, 16'h12CD);

    // read-during-write; q preloaded with addr 3 contents
    wr(5, 16'h0011, 2'b11);
    rd(3, 8'hCD, 16'h12CD);
    address = 5; data16 = 16'h0022; be = 2'b11; wren = 1'b1; rden = 1'b1;
    @(posedge clock); #1;
    idle();
    if (LAT == 2) begin @(posedge clock); #1; end
    check("rdw0_q", {8'h00, if_m0.q}, 16'h0022);
    check("rdw0_qv", 16'(if_m0.q_valid), 16'd1);
    check("rdw1_q", {8'h00, if_m1.q}, 16'h0011);
    check("rdw1_qv", 16'(if_m1.q_valid), 16'd1);
    check("rdw2_q", {8'h00, if_m2.q}, 16'h00CD);
    check("rdw2_qv", 16'(if_m2.q_valid), 16'd0);
    check("rdw_w_q", if_w.q, 16'h0022);
    @(negedge clock);

    // wren with no lanes enabled writes nothing
    wr(5, 16'h9999, 2'b00);
    rd(5, 8'h22, 16'h0022);

    // read latency
    wr(1, 16'h003C, 2'b11);
    address = 1; rden = 1'b1;
    @(posedge clock); #1;
    idle();
    check("lat_edge1_qv", 16'(if_m0.q_valid), 16'(LAT == 1));
    @(posedge clock); #1;
    check("lat_edge2_qv", 16'(if_m0.q_valid), 16'(LAT == 2));
    check("lat_edge2_q", {8'h00, if_m0.q}, 16'h003C);
    @(negedge clock);

    // clear_req with a same-cycle read, then ignored traffic while busy
    wr(2, 16'h0077, 2'b11);
    address = 2; rden = 1'b1; clear_req = 1'b1;
    @(posedge clock); #1;
    check("clr_req_busy", 16'(if_m0.busy), 16'd1);
    @(negedge clock);
    count_sweep(1'b1, n);
    check("sweep_len_clr_req", 16'(n), 16'd16);
    rd(2, CLR8, CLR16);
    rd(3, CLR8, CLR16);

    // reset mid-sweep
    wr(9, 16'h0042, 2'b11);
    reset = 1'b1;
    #1;
    check("async_rst_busy", 16'(if_m0.busy), 16'd1);
    check("async_rst_q", {8'h00, if_m0.q}, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    count_sweep(1'b0, n);
    check("sweep_len_mid_reset", 16'(n), 16'd16);
    for (int a = 0; a < DEPTH; a++) rd(AW'(a), CLR8, CLR16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spram_be_clr.md
Name: spram_be_clr

Overview:
- Next-generation single-port synchronous RAM for the arcade cores (video/work RAM, sprite buffers).
- Adds per-byte write enables, a selectable read-during-write mode and a read-enable with a q_valid strobe.
- Adds a hardware clear sequencer that fills the array with a constant after reset or on request.
- Drop-in for the existing generic single-port RAM wherever cores need cold-boot-clean memory.

Parameters:
- address_width, 8, address bits; depth = 2**address_width.
- data_width, 8, word width; must be a multiple of byte_width.
- byte_width, 8, bits per byte lane; lanes = data_width/byte_width.
- rdw_mode, 0, read-during-write behaviour: 0 = write-first (q = new merged word), 1 = read-first (q = old word), 2 = no-change (q holds).
- clear_value, 0, data_width pattern written to every word by the clear sequencer.

Ports:
- clock, input, 1, sole clock; all logic is rising-edge.
- reset, input, 1, asynchronous active-high reset; starts a clear sweep.
- address, input, address_width, word address.
- data, input, data_width, write data.
- byte_en, input, data_width/byte_width, per-lane write enable; bit i covers data[i*byte_width +: byte_width].
- wren, input, 1, write strobe.
- rden, input, 1, read strobe.
- clear_req, input, 1, one-cycle pulse; restarts the clear sweep.
- q, output, data_width, read data.
- q_valid, output, 1, high for one cycle with q on each accepted read.
- busy, output, 1, high while the clear sweep runs.

Behaviour:
- Reset (async assert): state=CLEAR, clr_addr=0, busy=1, q=0, q_valid=0. The memory array itself is never reset; it is cleared only by the sweep.
- States are CLEAR and IDLE.
- CLEAR:
  - Each cycle writes clear_value to mem[clr_addr] (all lanes) and increments clr_addr.
  - After the write at clr_addr = 2**address_width-1, go to IDLE and deassert busy on the next edge.
  - A sweep takes exactly 2**address_width cycles after reset release.
- IDLE: a clear_req pulse goes to CLEAR with clr_addr=0. busy asserts on the following cycle; the user access presented in that same cycle is still accepted.
- While busy:
  - User wren/rden are ignored: no write, q holds, q_valid=0.
  - clear_req is ignored; the sweep does not restart.
- Write (IDLE, wren=1): for each lane with byte_en[i]=1, mem[address] lane i takes data lane i. Other lanes keep their old value. wren with byte_en=0 writes nothing.
- Read (IDLE, rden=1, wren=0): q = mem[address] one clock later; q_valid=1 in that cycle.
- Read-during-write (IDLE, rden=1, wren=1), one cycle later:
  - rdw_mode 0: q = merged new word; q_valid=1.
  - rdw_mode 1: q = pre-write word; q_valid=1.
  - rdw_mode 2: q holds its prior value; q_valid=0.
- wren=1 with rden=0: q holds, q_valid=0.
- Read latency is 1 cycle; q holds between reads.
- Reset asserted mid-sweep restarts the sweep from address 0.
- An illegal parameter combination (data_width not divisible by byte_width, or rdw_mode>2) is stopped by an elaboration-time check.

Optional Feature:
- SPRAM_BE_CLR_OUTREG_EN defined:
  - Adds a second output register stage; q and q_valid arrive 2 cycles after the request.
  - Both stages reset to 0.
  - The busy/clear timing is unchanged.
  - The second stage advances every cycle.
- Undefined: 1-cycle latency as above.

Decomposition:
- Package spram_be_clr_pkg holds:
  - RDW_WRITE_FIRST=0, RDW_READ_FIRST=1, RDW_NO_CHANGE=2;
  - the state enum {ST_CLEAR, ST_IDLE};
  - a function returning lanes = data_width/byte_width.
- Sub-module spram_be_clr_seq: the clear FSM and address counter, with outputs busy, clr_we, clr_addr.
- The top level muxes the sweep and user paths into the array and implements the byte-lane merge and rdw_mode.

Test Plan:
- Clear after reset (address_width=4, clear_value=8'hA5): release reset, then read all 16 addresses → busy high exactly 16 cycles; every read returns 8'hA5 with q_valid.
- Byte enables (data_width=16, byte_width=8): write 16'h1234 at addr 3 with byte_en=2'b11, then 16'hABCD with byte_en=2'b01, then read addr 3 → q=16'h12CD.
- Read-during-write: for each rdw_mode, mem[5]=8'h11, then rden=wren=1 with data 8'h22 → modes 0/1/2 give q=8'h22 / 8'h11 / q held with q_valid=0.
- clear_req mid-run: write 8'h77 to addr 2, pulse clear_req, and attempt a write during busy → attempted write ignored; after busy falls, addr 2 reads clear_value.
- Reset mid-sweep: assert reset at sweep cycle 7 and release → busy stays high for a full 16 cycles after release; all words read clear_value.
- SPRAM_BE_CLR_OUTREG_EN: a read of addr 1 (8'h3C) → q=8'h3C and q_valid exactly 2 cycles after rden.
